// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ---- adder_arb_pkg : state encoding and defaults for the shared-adder arbiter -- rev 1.0 ----
package adder_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE     = 2'd0;
  localparam state_t ISSUE    = 2'd1;
  localparam state_t WAIT_RES = 2'd2;
  localparam state_t RETURN   = 2'd3;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_OPW     = 1;
  localparam int DEF_CNTW    = 16;

  // Unit result carries one extra bit for the carry-out.
  function automatic int res_width(input int opw);
    return opw + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---- rr_arbiter : combinational round-robin pick, first request at or above ptr_i with wrap -- rev 1.0 ----
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] winner_o,
  output logic          any_o
);

  logic [PW:0] cand;

  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      // ptr_i < N and k < N, so one conditional subtract is enough to wrap.
      cand = {1'b0, ptr_i} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) begin
        cand = cand - (PW+1)'(N);
      end
      if (!any_o && req_i[cand[PW-1:0]]) begin
        any_o    = 1'b1;
        winner_o = cand[PW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adder_stream_arbiter.sv
`default_nettype none
// ---- adder_stream_arbiter : round-robin sharing of one AXI-Stream unit adder, one transaction in flight -- rev 1.0 ----
// ---- Optional per-requester completion counters: define ADDER_ARB_STATS_EN ----
module adder_stream_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int OPW     = DEF_OPW,
`ifdef ADDER_ARB_STATS_EN
  parameter int CNTW    = DEF_CNTW,
`endif
  parameter int RESW    = res_width(OPW)
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic [NUM_REQ-1:0]          req_tvalid,
  output logic [NUM_REQ-1:0]          req_tready,
  input  logic [NUM_REQ*OPW-1:0]      req_a_tdata,
  input  logic [NUM_REQ*OPW-1:0]      req_b_tdata,
  output logic [RESW-1:0]             rsp_tdata,
  output logic [NUM_REQ-1:0]          rsp_tvalid,
  input  logic [NUM_REQ-1:0]          rsp_tready,
  output logic [OPW-1:0]              u_a_tdata,
  output logic                        u_a_tvalid,
  input  logic                        u_a_tready,
  output logic [OPW-1:0]              u_b_tdata,
  output logic                        u_b_tvalid,
  input  logic                        u_b_tready,
  input  logic [RESW-1:0]             u_result_tdata,
  input  logic                        u_tvalid,
  output logic                        u_tready,
  output logic                        busy,
`ifdef ADDER_ARB_STATS_EN
  output logic [NUM_REQ*CNTW-1:0]     stat_count,
`endif
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int IDW = $clog2(NUM_REQ);

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_q, grant_q, winner;
  logic             any_req;
  logic [OPW-1:0]   a_q, b_q, sel_a, sel_b;
  logic             a_sent_q, b_sent_q;
  logic [RESW-1:0]  res_q;
  logic             req_hs, a_hs, b_hs, res_hs, rsp_hs;
  logic [NUM_REQ-1:0] winner_oh, owner_oh;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (IDW)
  ) u_rr (
    .req_i    (req_tvalid),
    .ptr_i    (rr_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  assign winner_oh = NUM_REQ'(1) << winner;
  assign owner_oh  = NUM_REQ'(1) << grant_q;

  assign req_hs = (state_q == IDLE) && any_req;
  assign a_hs   = u_a_tvalid && u_a_tready;
  assign b_hs   = u_b_tvalid && u_b_tready;
  assign res_hs = u_tvalid && u_tready;
  assign rsp_hs = (state_q == RETURN) && rsp_tready[grant_q];

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_a = req_a_tdata[i*OPW +: OPW];
        sel_b = req_b_tdata[i*OPW +: OPW];
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (any_req) state_d = ISSUE;
      // A channel may finish on the very edge the other one does.
      ISSUE:    if ((a_sent_q || a_hs) && (b_sent_q || b_hs)) state_d = WAIT_RES;
      WAIT_RES: if (u_tvalid) state_d = RETURN;
      RETURN:   if (rsp_tready[grant_q]) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_tready = '0;
    rsp_tvalid = '0;
    u_a_tvalid = 1'b0;
    u_b_tvalid = 1'b0;
    u_tready   = 1'b0;
    case (state_q)
      IDLE:     if (any_req) req_tready = winner_oh;
      ISSUE: begin
        u_a_tvalid = !a_sent_q;
        u_b_tvalid = !b_sent_q;
      end
      WAIT_RES: u_tready = 1'b1;
      RETURN:   rsp_tvalid = owner_oh;
      default:  ;
    endcase
  end

  assign u_a_tdata = a_q;
  assign u_b_tdata = b_q;
  assign rsp_tdata = res_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rr_q     <= '0;
      grant_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      a_sent_q <= 1'b0;
      b_sent_q <= 1'b0;
      res_q    <= '0;
    end else begin
      if (req_hs) begin
        a_q      <= sel_a;
        b_q      <= sel_b;
        grant_q  <= winner;
        a_sent_q <= 1'b0;
        b_sent_q <= 1'b0;
      end
      if (a_hs) a_sent_q <= 1'b1;
      if (b_hs) b_sent_q <= 1'b1;
      if (res_hs) res_q <= u_result_tdata;
      // Pointer moves only on completion, so a stalled owner keeps its turn.
      if (rsp_hs) begin
        rr_q <= (grant_q == IDW'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

`ifdef ADDER_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [CNTW-1:0] cnt_q;
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        cnt_q <= '0;
      end else if (rsp_hs && (grant_q == IDW'(i)) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign stat_count[i*CNTW +: CNTW] = cnt_q;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_stream_arbiter.sv
`default_nettype none
// ---- tb_adder_stream_arbiter : vector table, directed corner sequences and randomized traffic vs. a queue model ----
module tb_adder_stream_arbiter;

  localparam int N    = 4;
  localparam int OPW  = 1;
  localparam int RESW = 2;
  localparam int IDW  = 2;
`ifdef ADDER_ARB_STATS_EN
  localparam int CNTW = 2;
  logic [N*CNTW-1:0] stat_count;
`endif

  logic            clk = 1'b0;
  logic            arst_n = 1'b0;
  logic [N-1:0]    req_tvalid = '0, req_tready, rsp_tvalid, rsp_tready = '0;
  logic [N*OPW-1:0] req_a_tdata = '0, req_b_tdata = '0;
  logic [RESW-1:0] rsp_tdata, u_result_tdata = '0;
  logic [OPW-1:0]  u_a_tdata, u_b_tdata;
  logic            u_a_tvalid, u_b_tvalid, u_a_tready = 1'b0, u_b_tready = 1'b0;
  logic            u_tvalid = 1'b0, u_tready, busy;
  logic [IDW-1:0]  grant_id;

  always #5 clk = ~clk;

  adder_stream_arbiter #(
    .NUM_REQ (N),
    .OPW     (OPW),
`ifdef ADDER_ARB_STATS_EN
    .CNTW    (CNTW),
`endif
    .RESW    (RESW)
  ) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .req_tvalid     (req_tvalid),
    .req_tready     (req_tready),
    .req_a_tdata    (req_a_tdata),
    .req_b_tdata    (req_b_tdata),
    .rsp_tdata      (rsp_tdata),
    .rsp_tvalid     (rsp_tvalid),
    .rsp_tready     (rsp_tready),
    .u_a_tdata      (u_a_tdata),
    .u_a_tvalid     (u_a_tvalid),
    .u_a_tready     (u_a_tready),
    .u_b_tdata      (u_b_tdata),
    .u_b_tvalid     (u_b_tvalid),
    .u_b_tready     (u_b_tready),
    .u_result_tdata (u_result_tdata),
    .u_tvalid       (u_tvalid),
    .u_tready       (u_tready),
    .busy           (busy),
`ifdef ADDER_ARB_STATS_EN
    .stat_count     (stat_count),
`endif
    .grant_id       (grant_id)
  );

  // Reference model: per-requester operand queues, one transaction phase
  // (0 idle, 1 issuing, 2 awaiting result, 3 returning) and the rr pointer.
  logic [2*OPW-1:0] pend [N][$];
  int ptr, phase, owner, cyc, hs_cyc, rsp_cyc, a_cyc, b_cyc, na, nb;
  logic [OPW-1:0] cur_a, cur_b, rcv_a, rcv_b;
  logic [RESW-1:0] last_rsp;
  bit got_a, got_b, unit_busy, rsp_seen, rand_mode;
  int unit_wait, unit_lat, ua_hold, rsp_hold, done_cnt;
  int done_per [N];
  int grant_log [$];
  int checks = 0, errors = 0;

  typedef struct {
    int             idx;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    int             lat;
    logic [RESW-1:0] exp;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      pend[i].delete();
      done_per[i] = 0;
    end
    ptr = 0; phase = 0; owner = 0; unit_busy = 0; unit_wait = 0;
    ua_hold = 0; rsp_hold = 0; got_a = 0; got_b = 0;
  endtask

  task automatic cycle();
    int pred, ph;
    logic [2*OPW-1:0] e;
    @(negedge clk);
    cyc++;
    if (rand_mode && $urandom_range(0, 2) == 0) begin
      pred = $urandom_range(0, N-1);
      if (pend[pred].size() < 4) pend[pred].push_back((2*OPW)'($urandom()));
    end
    for (int i = 0; i < N; i++) begin
      req_tvalid[i] = (pend[i].size() > 0);
      e = (pend[i].size() > 0) ? pend[i][0] : '0;
      req_a_tdata[i*OPW +: OPW] = e[2*OPW-1:OPW];
      req_b_tdata[i*OPW +: OPW] = e[OPW-1:0];
    end
    if (rand_mode) begin
      u_a_tready = 1'($urandom_range(0, 1));
      u_b_tready = 1'($urandom_range(0, 1));
      rsp_tready = N'($urandom());
    end else begin
      u_a_tready = !(phase == 1 && ua_hold > 0);
      u_b_tready = 1'b1;
      rsp_tready = (phase == 3 && rsp_hold > 0) ? '0 : '1;
    end
    u_tvalid       = unit_busy && (unit_wait == 0);
    u_result_tdata = u_tvalid ? (RESW'(rcv_a) + RESW'(rcv_b)) : '0;
    #1;
    ph = phase;
    chk("busy", busy, ph != 0);
    chk("u_tready", u_tready, ph == 2);
    chk("req_tready_onehot", $countones(req_tready) <= 1, 1);
    if (ph != 0) chk("grant_id", grant_id, owner);
    if (ph != 1) chk("u_valid_idle", {u_a_tvalid, u_b_tvalid}, 0);
    if (ph != 3) chk("rsp_tvalid_idle", rsp_tvalid, 0);
    if (ph != 0) chk("req_tready_busy", req_tready, 0);
    if (ph == 0) begin
      pred = -1;
      for (int k = 0; k < N; k++) begin
        if (pred < 0 && pend[(ptr + k) % N].size() > 0) pred = (ptr + k) % N;
      end
      chk("req_tready", req_tready, (pred < 0) ? 0 : (1 << pred));
      if (pred >= 0) begin
        owner = pred;
        {cur_a, cur_b} = pend[pred].pop_front();
        phase = 1; got_a = 0; got_b = 0; rsp_seen = 0; na = 0; nb = 0;
        grant_log.push_back(pred);
        hs_cyc = cyc;
      end
    end else if (ph == 1) begin
      chk("u_a_tvalid", u_a_tvalid, !got_a);
      chk("u_b_tvalid", u_b_tvalid, !got_b);
      if (u_a_tvalid && u_a_tready) begin
        chk("u_a_tdata", u_a_tdata, cur_a);
        got_a = 1; rcv_a = u_a_tdata; na++; a_cyc = cyc;
      end
      if (u_b_tvalid && u_b_tready) begin
        chk("u_b_tdata", u_b_tdata, cur_b);
        got_b = 1; rcv_b = u_b_tdata; nb++; b_cyc = cyc;
      end
      if (!u_a_tready && ua_hold > 0) ua_hold--;
      if (got_a && got_b) begin
        phase = 2;
        unit_busy = 1;
        unit_wait = rand_mode ? $urandom_range(0, 3) : unit_lat - 1;
      end
    end else if (ph == 2) begin
      if (u_tvalid && u_tready) begin
        unit_busy = 0;
        phase = 3;
      end else if (unit_wait > 0) begin
        unit_wait--;
      end
    end else begin
      if (!rsp_seen) begin
        rsp_seen = 1;
        rsp_cyc = cyc;
      end
      chk("rsp_tvalid", rsp_tvalid, 1 << owner);
      chk("rsp_tdata", rsp_tdata, RESW'(cur_a) + RESW'(cur_b));
      if (rsp_tready[owner]) begin
        last_rsp = rsp_tdata;
        phase = 0;
        ptr = (owner + 1) % N;
        done_cnt++;
        done_per[owner]++;
      end else if (rsp_hold > 0) begin
        rsp_hold--;
      end
    end
  endtask

  task automatic run_until(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      cycle();
      n++;
    end
    chk("completion_budget", done_cnt, target);
  endtask

  task automatic run_to_phase(input int p, input int budget);
    int n;
    n = 0;
    while (phase != p && n < budget) begin
      cycle();
      n++;
    end
    chk("phase_budget", phase, p);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    arst_n = 1'b0;
    req_tvalid = '0; rsp_tready = '0; u_tvalid = 1'b0;
    u_a_tready = 1'b0; u_b_tready = 1'b0;
    #1;
    chk("rst_req_tready", req_tready, 0);
    chk("rst_rsp_tvalid", rsp_tvalid, 0);
    chk("rst_u_valids", {u_a_tvalid, u_b_tvalid, u_tready}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_rsp_tdata", rsp_tdata, 0);
    chk("rst_u_data", {u_a_tdata, u_b_tdata}, 0);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    tbl[0] = '{0, 1'b1, 1'b1, 1, 2'b10};
    tbl[1] = '{1, 1'b1, 1'b0, 2, 2'b01};
    tbl[2] = '{2, 1'b0, 1'b1, 1, 2'b01};
    tbl[3] = '{3, 1'b0, 1'b0, 3, 2'b00};
    tbl[4] = '{3, 1'b1, 1'b1, 1, 2'b10};
    tbl[5] = '{0, 1'b0, 1'b1, 2, 2'b01};
    cyc = 0; done_cnt = 0; rand_mode = 0; unit_lat = 1;
    clear_model();
    apply_reset();

    // All four requesters at once: two full rounds starting from requester 0.
    grant_log.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) pend[i].push_back((2*OPW)'($urandom()));
    run_until(done_cnt + 8, 100);
    for (int k = 0; k < 8; k++)
      chk("rr_order", (k < grant_log.size()) ? grant_log[k] : -1, k % N);

    // Table of single transactions with varying unit latency.
    for (int t = 0; t < 6; t++) begin
      pend[tbl[t].idx].push_back({tbl[t].a, tbl[t].b});
      unit_lat = tbl[t].lat;
      run_until(done_cnt + 1, 40);
      chk("tbl_result", last_rsp, tbl[t].exp);
      chk("tbl_latency", rsp_cyc - hs_cyc, 2 + tbl[t].lat);
    end

    // Operand A stalled three ISSUE cycles while B is accepted at once.
    unit_lat = 1;
    ua_hold = 3;
    pend[0].push_back({1'b1, 1'b1});
    run_until(done_cnt + 1, 40);
    chk("stall_a_count", na, 1);
    chk("stall_b_count", nb, 1);
    chk("stall_b_cycle", b_cyc - hs_cyc, 1);
    chk("stall_a_cycle", a_cyc - hs_cyc, 4);
    chk("stall_result", last_rsp, 2'b10);

    // Response held five cycles while requester 2 waits behind it.
    grant_log.delete();
    pend[1].push_back({1'b1, 1'b0});
    run_to_phase(3, 20);
    rsp_hold = 5;
    pend[2].push_back({1'b1, 1'b1});
    base = cyc;
    run_until(done_cnt + 1, 30);
    chk("hold_duration", cyc - base >= 5, 1);
    run_until(done_cnt + 1, 30);
    chk("hold_order0", grant_log.size() > 0 ? grant_log[0] : -1, 1);
    chk("hold_order1", grant_log.size() > 1 ? grant_log[1] : -1, 2);
    chk("hold_result", last_rsp, 2'b10);

    // Reset while the unit owes a result; requester 3 is then served cleanly.
    unit_lat = 3;
    pend[0].push_back({1'b1, 1'b1});
    run_to_phase(2, 20);
    apply_reset();
    grant_log.delete();
    unit_lat = 1;
    pend[3].push_back({1'b1, 1'b0});
    run_until(done_cnt + 1, 40);
    chk("post_rst_grant", grant_log.size() > 0 ? grant_log[0] : -1, 3);
    chk("post_rst_result", last_rsp, 2'b01);

    // Randomized traffic, readies and unit latency, then drain.
    rand_mode = 1;
    for (int i = 0; i < 600; i++) cycle();
    rand_mode = 0;
    base = 0;
    while ((phase != 0 || pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size() > 0)
           && base < 300) begin
      cycle();
      base++;
    end
    chk("drain", phase + pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size(), 0);

`ifdef ADDER_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      chk("stat_count", stat_count[i*CNTW +: CNTW], (done_per[i] > 3) ? 3 : done_per[i]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
